mod_mult_cinv_seq: RTL

Sequential modular multiplier by the inverse constant: it computes result = OP_A · CONST_INV mod MODULUS, so it undoes the ROM-based constant multiplier on the same residue channel. It is the decode side of the TPU residue datapath, used to recover operands and to cross-check forward products. It uses no ROM/MLAB: 18-iteration double-and-add with valid/ready handshakes on both sides.

---
 rtl/mod_mult_cinv_pkg.sv | 15 +
 rtl/mod_add_cond.sv | 21 ++
 rtl/mod_mult_cinv_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/mod_mult_cinv_pkg.sv
// Shared types and default channel constants for the inverse-constant modular multiplier.
package mod_mult_cinv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH = 18;
  localparam int unsigned DEF_MODULUS    = 177147;
  localparam int unsigned DEF_CONST_INV  = 88574;
  localparam int unsigned DEF_IDX_W      = $clog2(DEF_DATA_WIDTH);

endpackage

// File: rtl/mod_add_cond.sv
// Modular add of two reduced residues: one extra bit of headroom, then a single conditional subtract.
module mod_add_cond #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned MODULUS    = 177147
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum_c
);

  localparam int unsigned   XW    = DATA_WIDTH + 1;
  localparam logic [XW-1:0] MOD_X = XW'(MODULUS);

  logic [XW-1:0] raw;

  always_comb begin
    raw   = XW'(a) + XW'(b);
    sum_c = DATA_WIDTH'((raw >= MOD_X) ? (raw - MOD_X) : raw);
  end

endmodule

// File: rtl/mod_mult_cinv_seq.sv
// Sequential OP_A * CONST_INV mod MODULUS by MSB-first double-and-add, one constant bit per cycle.
module mod_mult_cinv_seq
  import mod_mult_cinv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MODULUS    = DEF_MODULUS,
  parameter int unsigned CONST_INV  = DEF_CONST_INV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] OP_A,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int unsigned           IDX_W   = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MOD_D   = DATA_WIDTH'(MODULUS);
  localparam logic [DATA_WIDTH-1:0] CINV_D  = DATA_WIDTH'(CONST_INV);
  localparam logic [IDX_W-1:0]      IDX_TOP = IDX_W'(DATA_WIDTH - 1);

  // The single-subtract input reduction relies on MODULUS sitting in the top half of the range.
  if ((MODULUS <= (32'd1 << (DATA_WIDTH - 1))) || (MODULUS >= (32'd1 << DATA_WIDTH))) begin : g_bad_modulus
    $error("mod_mult_cinv_seq: MODULUS must satisfy 2^(DATA_WIDTH-1) < MODULUS < 2^DATA_WIDTH");
  end
  if (CONST_INV >= MODULUS) begin : g_bad_const_inv
    $error("mod_mult_cinv_seq: CONST_INV must be below MODULUS");
  end

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] a_reg, a_nx;
  logic [DATA_WIDTH-1:0] acc, acc_nx;
  logic [DATA_WIDTH-1:0] result_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [DATA_WIDTH-1:0] dbl, add_out, step;

  mod_add_cond #(.DATA_WIDTH(DATA_WIDTH), .MODULUS(MODULUS)) u_dbl (
    .a     (acc),
    .b     (acc),
    .sum_c (dbl)
  );

  mod_add_cond #(.DATA_WIDTH(DATA_WIDTH), .MODULUS(MODULUS)) u_add (
    .a     (dbl),
    .b     (a_reg),
    .sum_c (add_out)
  );

  assign step = CINV_D[idx] ? add_out : dbl;

  // Next-state and datapath update.
  always_comb begin
    state_nx  = state;
    a_nx      = a_reg;
    acc_nx    = acc;
    idx_nx    = idx;
    result_nx = result;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_nx     = (OP_A >= MOD_D) ? (OP_A - MOD_D) : OP_A;
          acc_nx   = '0;
          idx_nx   = IDX_TOP;
          state_nx = RUN;
        end
      end
      RUN: begin
        acc_nx = step;
        if (idx == '0) begin
          result_nx = step;
          state_nx  = DONE;
        end else begin
          idx_nx = idx - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they never depend on inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      acc       <= '0;
      idx       <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      a_reg     <= a_nx;
      acc       <= acc_nx;
      idx       <= idx_nx;
      result    <= result_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
    end
  end

endmodule
